sid_write_arbiter: RTL

- Shares the single SID register-write port (addr/voice/data plus write strobe on ui_in[7]) between two independent requesters, e.g. a sequencer core and a host/SPI bridge.
- Arbitrates round-robin and serialises the accepted writes.
- Generates the strobe timing the SID core requires: setup, strobe-high, hold.
- Sits directly in front of the ui_in/uio_in register interface of tt_um_sid.

---
 rtl/sid_write_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/sid_write_arbiter.sv
// Round-robin arbiter serialising two requesters onto the SID register-write port with setup/strobe/hold timing.
// Optional shadow readback register file is enabled by defining SID_ARB_SHADOW_EN.
module sid_write_arbiter #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic [12:0] req0_payload,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [12:0] req1_payload,
    output logic        req1_ready,
    output logic [1:0]  bus_voice,
    output logic [2:0]  bus_addr,
    output logic [7:0]  bus_data,
    output logic        bus_we,
    output logic        busy
`ifdef SID_ARB_SHADOW_EN
    ,
    input  logic [1:0]  rd_voice,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data
`endif
);

    // A phase length of 0 behaves like 1; the counter counts down from length-1.
    function automatic logic [3:0] phase_load(input int unsigned n);
        return (n == 0) ? 4'd0 : 4'(n - 1);
    endfunction

    localparam logic [3:0] SETUP_LD  = phase_load(SETUP_CYC);
    localparam logic [3:0] STROBE_LD = phase_load(STROBE_CYC);
    localparam logic [3:0] HOLD_LD   = phase_load(HOLD_CYC);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_rr_last;
    logic [12:0] r_payload;
    logic        r_we;
    logic        w_we_nxt;
    logic        w_req_any;
    logic        w_grant_idx;
    logic        w_accept;
    logic [12:0] w_payload_sel;

    assign w_req_any = req0_valid | req1_valid;

    // On a tie the requester that did not win last time is served.
    always_comb begin
        w_grant_idx = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_idx = ~r_rr_last;
        end else if (req1_valid) begin
            w_grant_idx = 1'b1;
        end
    end

    assign w_payload_sel = w_grant_idx ? req1_payload : req0_payload;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = STROBE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = HOLD_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    assign w_we_nxt = (w_state_nxt == S_STROBE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_we    <= w_we_nxt;
        end
    end

    // Payload register doubles as the bus driver, so it holds its value across IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_payload <= '0;
            r_rr_last <= 1'b1;
        end else if (w_accept) begin
            r_payload <= w_payload_sel;
            r_rr_last <= w_grant_idx;
        end
    end

    assign req0_ready = rst_n & w_accept & ~w_grant_idx;
    assign req1_ready = rst_n & w_accept &  w_grant_idx;
    assign bus_voice  = r_payload[12:11];
    assign bus_addr   = r_payload[10:8];
    assign bus_data   = r_payload[7:0];
    assign bus_we     = r_we;
    assign busy       = (r_state != S_IDLE);

`ifdef SID_ARB_SHADOW_EN
    logic [7:0] r_shadow [32];
    logic       w_we_rise;

    assign w_we_rise = w_we_nxt & ~r_we;

    // {voice, addr} is exactly payload[12:8], which indexes the shadow directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (w_we_rise) begin
            r_shadow[r_payload[12:8]] <= r_payload[7:0];
        end
    end

    assign rd_data = r_shadow[{rd_voice, rd_addr}];
`endif

endmodule
